// File: rtl/multi_mode_countdown.sv
// multi_mode_countdown
//   Minutes/seconds countdown timer with one-shot and auto-reload modes,
//   pause/resume that keeps the fraction of the current second, and a
//   blinking "finished" indicator.
//
// Parameters
//   TICK_DIV    clk cycles per 1 s tick
//   MIN_W       width of the minutes field
//   MAX_MIN     largest loadable minutes value
//   BLINK_HALF  clk cycles per blink half-period
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   load         in   pulse: capture load_min/load_sec (clamped) and go IDLE
//   load_min     in   preset minutes
//   load_sec     in   preset seconds
//   start        in   pulse: start, or restart from the preset
//   pause        in   pulse: toggle RUN/PAUSED
//   auto_reload  in   level: 1 = periodic, 0 = one-shot
//   min_out      out  current minutes
//   sec_out      out  current seconds (0..59)
//   running      out  high in RUN
//   finish       out  high in DONE
//   done_pulse   out  one-cycle pulse on every expiry
//   blink        out  50% square wave while in DONE, else 0

module multi_mode_countdown #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned MIN_W      = 7,
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [MIN_W-1:0] min_out,
  output logic [5:0]       sec_out,
  output logic             running,
  output logic             finish,
  output logic             done_pulse,
  output logic             blink
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [MIN_W-1:0] MAX_MIN_V  = MIN_W'(MAX_MIN);
  localparam logic [MIN_W-1:0] MIN_ONE    = MIN_W'(1);
  localparam logic [31:0]      TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0]      BLINK_LAST = 32'(BLINK_HALF - 1);

  state_t           state;
  logic [31:0]      tick_cnt;
  logic [31:0]      blink_cnt;
  logic [MIN_W-1:0] preset_min;
  logic [5:0]       preset_sec;
  logic             reload_pending;

  logic [MIN_W-1:0] clamp_min;
  logic [5:0]       clamp_sec;
  logic [MIN_W-1:0] dec_min;
  logic [5:0]       dec_sec;
  logic             tick;
  logic             preset_zero;
  logic             count_zero;
  logic             expire;
  logic             go_done;
  logic             start_ok;

  // Saturate out-of-range load values instead of rejecting them.
  always_comb begin
    clamp_min = load_min;
    clamp_sec = load_sec;
    if (load_min > MAX_MIN_V) clamp_min = MAX_MIN_V;
    if (load_sec > 6'd59) clamp_sec = 6'd59;
  end

  // Value the display would take on the next one-second decrement.
  always_comb begin
    dec_min = min_out;
    dec_sec = sec_out;
    if (sec_out != 6'd0) begin
      dec_sec = sec_out - 6'd1;
    end else if (min_out != '0) begin
      dec_min = min_out - MIN_ONE;
      dec_sec = 6'd59;
    end
  end

  assign tick        = (tick_cnt == TICK_LAST);
  assign preset_zero = (preset_min == '0) && (preset_sec == 6'd0);
  assign count_zero  = (min_out == '0) && (sec_out == 6'd0);
  // A tick that is consuming a pending reload is not an expiry, even at 00:00.
  assign expire      = tick && !reload_pending && (dec_min == '0) && (dec_sec == 6'd0);
  // auto_reload is only looked at here, so a change waits for the next expiry.
  assign go_done     = expire && !(auto_reload && !preset_zero);
  assign start_ok    = start && !((state == IDLE) && count_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      blink_cnt      <= '0;
      preset_min     <= '0;
      preset_sec     <= '0;
      reload_pending <= 1'b0;
      min_out        <= '0;
      sec_out        <= '0;
      running        <= 1'b0;
      finish         <= 1'b0;
      done_pulse     <= 1'b0;
      blink          <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (load) begin
        preset_min     <= clamp_min;
        preset_sec     <= clamp_sec;
        min_out        <= clamp_min;
        sec_out        <= clamp_sec;
        tick_cnt       <= '0;
        blink_cnt      <= '0;
        reload_pending <= 1'b0;
        state          <= IDLE;
        running        <= 1'b0;
        finish         <= 1'b0;
        blink          <= 1'b0;
      end else if (start_ok) begin
        // In IDLE the display already equals the preset, so reloading is harmless.
        min_out        <= preset_min;
        sec_out        <= preset_sec;
        tick_cnt       <= '0;
        blink_cnt      <= '0;
        reload_pending <= 1'b0;
        state          <= RUN;
        running        <= 1'b1;
        finish         <= 1'b0;
        blink          <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (tick) begin
              tick_cnt <= '0;
              if (reload_pending) begin
                // 00:00 has been shown for one full tick; restart the period.
                min_out        <= preset_min;
                sec_out        <= preset_sec;
                reload_pending <= 1'b0;
              end else begin
                min_out <= dec_min;
                sec_out <= dec_sec;
                if (expire) done_pulse <= 1'b1;
                if (expire && !go_done) reload_pending <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 32'd1;
            end
            if (go_done) begin
              state     <= DONE;
              running   <= 1'b0;
              finish    <= 1'b1;
              blink     <= 1'b1;
              blink_cnt <= '0;
            end else if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
          end
          PAUSED: begin
            // tick_cnt is deliberately left alone so the partial second survives.
            if (pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              blink     <= ~blink;
            end else begin
              blink_cnt <= blink_cnt + 32'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_countdown.sv
// Testbench for multi_mode_countdown (TICK_DIV=10, BLINK_HALF=3, MIN_W=7,
// MAX_MIN=99). Expected values come from arithmetic on total seconds and
// elapsed running cycles rather than from a per-state model.

module tb_multi_mode_countdown;

  localparam int TD = 10;
  localparam int BH = 3;

  logic       clk;
  logic       rst;
  logic       load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic       auto_reload;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       running;
  logic       finish;
  logic       done_pulse;
  logic       blink;

  int assertCount = 0;
  int failCount   = 0;

  multi_mode_countdown #(
    .TICK_DIV(10),
    .MIN_W(7),
    .MAX_MIN(99),
    .BLINK_HALF(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_min(load_min),
    .load_sec(load_sec),
    .start(start),
    .pause(pause),
    .auto_reload(auto_reload),
    .min_out(min_out),
    .sec_out(sec_out),
    .running(running),
    .finish(finish),
    .done_pulse(done_pulse),
    .blink(blink)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one cycle of inputs; pulses drop after the edge.
  task automatic applyStimulus(input logic ld, input logic [6:0] m, input logic [5:0] s,
                               input logic st, input logic ps);
    load     = ld;
    load_min = m;
    load_sec = s;
    start    = st;
    pause    = ps;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_min"}, 32'(min_out), 0);
    checkOutput({tag, "_sec"}, 32'(sec_out), 0);
    checkOutput({tag, "_running"}, 32'(running), 0);
    checkOutput({tag, "_finish"}, 32'(finish), 0);
    checkOutput({tag, "_done_pulse"}, 32'(done_pulse), 0);
    checkOutput({tag, "_blink"}, 32'(blink), 0);
  endtask

  // One-shot reference: after 'elapsed' running cycles from a start with
  // 'total' seconds loaded, the display shows total - elapsed/TD seconds,
  // expiring at elapsed = total*TD and blinking in BH-cycle halves after.
  task automatic checkOneShot(input string tag, input int elapsed, input int total);
    int limit;
    int remaining;
    bit done;
    bit blinkExp;
    limit     = total * TD;
    done      = (elapsed >= limit);
    remaining = done ? 0 : total - elapsed / TD;
    blinkExp  = done ? (((elapsed - limit) / BH) % 2 == 0) : 1'b0;
    checkOutput({tag, "_min"}, 32'(min_out), 32'(remaining / 60));
    checkOutput({tag, "_sec"}, 32'(sec_out), 32'(remaining % 60));
    checkOutput({tag, "_running"}, 32'(running), 32'(!done));
    checkOutput({tag, "_finish"}, 32'(finish), 32'(done));
    checkOutput({tag, "_done_pulse"}, 32'(done_pulse), 32'(elapsed == limit));
    checkOutput({tag, "_blink"}, 32'(blink), 32'(blinkExp));
  endtask

  initial begin
    int m;
    int s;
    int total;
    int p;
    int h;
    int nAfter;
    int k;

    rst         = 1'b1;
    load        = 1'b0;
    load_min    = '0;
    load_sec    = '0;
    start       = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    checkAllZero("reset");

    // Clamping of oversized loads, fixed and random.
    applyStimulus(1'b1, 7'd120, 6'd63, 1'b0, 1'b0);
    checkOutput("clamp_min", 32'(min_out), 99);
    checkOutput("clamp_sec", 32'(sec_out), 59);
    for (int i = 0; i < 8; i++) begin
      m = $urandom_range(0, 127);
      s = $urandom_range(0, 63);
      applyStimulus(1'b1, 7'(m), 6'(s), 1'b0, 1'b0);
      checkOutput("rand_clamp_min", 32'(min_out), 32'((m > 99) ? 99 : m));
      checkOutput("rand_clamp_sec", 32'(sec_out), 32'((s > 59) ? 59 : s));
      checkOutput("rand_clamp_running", 32'(running), 0);
    end

    // Start with 00:00 loaded is ignored.
    applyStimulus(1'b1, 7'd0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    checkOutput("zero_start_running", 32'(running), 0);
    waitCycles(15);
    checkOutput("zero_start_running_late", 32'(running), 0);
    checkOutput("zero_start_sec", 32'(sec_out), 0);

    // One-shot 01:02 walked cycle by cycle through expiry and blinking.
    auto_reload = 1'b0;
    applyStimulus(1'b1, 7'd1, 6'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    checkOneShot("oneshot", 0, 62);
    for (int e = 1; e <= 640; e++) begin
      waitCycles(1);
      checkOneShot("oneshot", e, 62);
    end

    // Pause at running-cycle 4 for 50 cycles; decrement 6 cycles after resume.
    applyStimulus(1'b1, 7'd0, 6'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b0, 1'b1);
    checkOutput("pause_running", 32'(running), 0);
    for (int i = 0; i < 50; i++) begin
      waitCycles(1);
      checkOutput("paused_running", 32'(running), 0);
      checkOutput("paused_sec", 32'(sec_out), 5);
    end
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b0, 1'b1);
    checkOutput("resume_running", 32'(running), 1);
    waitCycles(5);
    checkOutput("resume_plus5_sec", 32'(sec_out), 5);
    waitCycles(1);
    checkOutput("resume_plus6_sec", 32'(sec_out), 4);
    for (int e = 11; e <= 55; e++) begin
      waitCycles(1);
      checkOneShot("after_pause", e, 5);
    end

    // Auto-reload 00:02: three-tick period, switched to one-shot mid-period.
    applyStimulus(1'b1, 7'd0, 6'd2, 1'b0, 1'b0);
    auto_reload = 1'b1;
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    for (int n = 1; n <= 115; n++) begin
      waitCycles(1);
      if (n == 95) auto_reload = 1'b0;
      k = n / TD;
      if (n < 110) begin
        checkOutput("auto_sec", 32'(sec_out), 32'(2 - (k % 3)));
        checkOutput("auto_min", 32'(min_out), 0);
        checkOutput("auto_pulse", 32'(done_pulse), 32'((n % TD == 0) && (k % 3 == 2)));
        checkOutput("auto_finish", 32'(finish), 0);
        checkOutput("auto_running", 32'(running), 1);
      end else begin
        checkOutput("auto_off_sec", 32'(sec_out), 0);
        checkOutput("auto_off_pulse", 32'(done_pulse), 32'(n == 110));
        checkOutput("auto_off_finish", 32'(finish), 1);
        checkOutput("auto_off_running", 32'(running), 0);
      end
    end

    // Collisions: load beats start; start beats pause.
    applyStimulus(1'b1, 7'd0, 6'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    waitCycles(3);
    applyStimulus(1'b1, 7'd0, 6'd7, 1'b1, 1'b0);
    checkOutput("load_start_running", 32'(running), 0);
    checkOutput("load_start_sec", 32'(sec_out), 7);
    checkOutput("load_start_finish", 32'(finish), 0);
    waitCycles(12);
    checkOutput("load_start_idle_sec", 32'(sec_out), 7);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    waitCycles(13);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b0, 1'b1);
    checkOutput("collide_paused_running", 32'(running), 0);
    checkOutput("collide_paused_sec", 32'(sec_out), 6);
    waitCycles(5);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b1);
    checkOutput("start_pause_running", 32'(running), 1);
    checkOutput("start_pause_sec", 32'(sec_out), 7);
    waitCycles(9);
    checkOutput("start_pause_9_sec", 32'(sec_out), 7);
    waitCycles(1);
    checkOutput("start_pause_10_sec", 32'(sec_out), 6);

    // Reset mid-tick in RUN, then again in DONE.
    waitCycles(4);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkAllZero("rst_run");
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    checkOutput("rst_run_start_running", 32'(running), 0);
    waitCycles(12);
    checkOutput("rst_run_start_sec", 32'(sec_out), 0);
    applyStimulus(1'b1, 7'd0, 6'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    waitCycles(10);
    checkOutput("pre_rst_done_finish", 32'(finish), 1);
    checkOutput("pre_rst_done_blink", 32'(blink), 1);
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkAllZero("rst_done");
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    checkOutput("rst_done_start_running", 32'(running), 0);
    applyStimulus(1'b1, 7'd0, 6'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
    checkOutput("reload_start_running", 32'(running), 1);
    checkOutput("reload_start_sec", 32'(sec_out), 3);

    // Random one-shot runs with a random pause somewhere before expiry.
    auto_reload = 1'b0;
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(0, 1);
      s = $urandom_range(0, 59);
      if (m == 0 && s == 0) s = 1;
      total  = m * 60 + s;
      p      = $urandom_range(1, total * TD - 1);
      h      = $urandom_range(1, 30);
      nAfter = $urandom_range(0, total * TD + 10 - p);
      applyStimulus(1'b1, 7'(m), 6'(s), 1'b0, 1'b0);
      applyStimulus(1'b0, 7'd0, 6'd0, 1'b1, 1'b0);
      waitCycles(p - 1);
      applyStimulus(1'b0, 7'd0, 6'd0, 1'b0, 1'b1);
      checkOutput("rand_pause_running", 32'(running), 0);
      checkOutput("rand_pause_sec", 32'(sec_out), 32'((total - p / TD) % 60));
      waitCycles(h);
      checkOutput("rand_hold_sec", 32'(sec_out), 32'((total - p / TD) % 60));
      checkOutput("rand_hold_min", 32'(min_out), 32'((total - p / TD) / 60));
      applyStimulus(1'b0, 7'd0, 6'd0, 1'b0, 1'b1);
      checkOutput("rand_resume_running", 32'(running), 1);
      waitCycles(nAfter);
      checkOneShot("rand_run", p + nAfter, total);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
